// File: rtl/pulse_timer_arbiter.sv
// pulse_timer_arbiter: one shared tick counter lent out to NREQ requesters.
// A round-robin arbiter picks the next owner, the counter counts ticks[owner]
// enabled edges, and the owner receives a single-cycle done pulse.
module pulse_timer_arbiter #(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] ticks,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [IDW-1:0]    active_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [N-1:0]      counter_r, counter_s;
  logic [N-1:0]      target_r, target_s;
  logic [IDW-1:0]    last_id_r, last_id_s;
  logic [NREQ-1:0]   grant_r, grant_s;
  logic [NREQ-1:0]   done_r, done_s;
  logic              busy_r, busy_s;
  logic [IDW-1:0]    active_id_r, active_id_s;
  logic              win_found_s;
  logic [IDW-1:0]    win_id_s;
  logic [N-1:0]      win_ticks_s;

  // Convert a requester index into its one-hot position.
  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << id;
  endfunction

  assign grant     = grant_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign active_id = active_id_r;

  // Round-robin search: first set req bit starting just above the last owner.
  always_comb begin : rr_search
    logic [IDW:0] cand_v;
    win_found_s = 1'b0;
    win_id_s    = {IDW{1'b0}};
    cand_v      = {(IDW+1){1'b0}};
    for (int off = 1; off <= NREQ; off++) begin
      cand_v = {1'b0, last_id_r} + (IDW+1)'(off);
      if (cand_v >= (IDW+1)'(NREQ)) begin
        cand_v = cand_v - (IDW+1)'(NREQ);
      end else begin
        cand_v = cand_v;
      end
      if (!win_found_s && req[cand_v[IDW-1:0]]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_v[IDW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
    win_ticks_s = ticks[win_id_s*N +: N];
  end

  // Next-state and next-output logic for the IDLE/COUNT/DONE sequence.
  always_comb begin
    state_s     = state_r;
    counter_s   = counter_r;
    target_s    = target_r;
    last_id_s   = last_id_r;
    grant_s     = {NREQ{1'b0}};
    done_s      = {NREQ{1'b0}};
    busy_s      = busy_r;
    active_id_s = active_id_r;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          grant_s     = onehot(win_id_s);
          active_id_s = win_id_s;
          busy_s      = 1'b1;
          counter_s   = {N{1'b0}};
          // A zero delay behaves exactly like a delay of one tick.
          target_s    = (win_ticks_s == {N{1'b0}}) ? {{(N-1){1'b0}}, 1'b1} : win_ticks_s;
          state_s     = ST_COUNT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (ena) begin
          if (counter_r == target_r - {{(N-1){1'b0}}, 1'b1}) begin
            done_s  = onehot(active_id_r);
            state_s = ST_DONE;
          end else begin
            counter_s = counter_r + {{(N-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = ST_COUNT;
        end
      end
      ST_DONE: begin
        busy_s    = 1'b0;
        last_id_s = active_id_r;
        state_s   = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset restarts arbitration at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      counter_r   <= {N{1'b0}};
      target_r    <= {N{1'b0}};
      last_id_r   <= IDW'(NREQ-1);
      grant_r     <= {NREQ{1'b0}};
      done_r      <= {NREQ{1'b0}};
      busy_r      <= 1'b0;
      active_id_r <= {IDW{1'b0}};
    end else begin
      state_r     <= state_s;
      counter_r   <= counter_s;
      target_r    <= target_s;
      last_id_r   <= last_id_s;
      grant_r     <= grant_s;
      done_r      <= done_s;
      busy_r      <= busy_s;
      active_id_r <= active_id_s;
    end
  end

endmodule

// File: tb/tb_pulse_timer_arbiter.sv
// Directed bench for pulse_timer_arbiter (N=8, NREQ=4).
module tb_pulse_timer_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [3:0]  req;
  logic [31:0] ticks;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  active_id;

  int errors = 0;
  int checks = 0;

  pulse_timer_arbiter #(.N(8), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .ticks(ticks),
    .grant(grant), .done(done), .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step until a done pulse appears or the limit expires; n = edges taken.
  task automatic run_until_done(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (done == 4'b0000 && n < limit);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp2 [4];
    logic [3:0] req3 [4];
    logic [3:0] exp3 [4];
    int n;
    int first_j;
    int done_cnt;
    logic [3:0] done_seen;

    exp2 = '{4'b0010, 4'b0100, 4'b0001, 4'b0010};
    req3 = '{4'b1001, 4'b1001, 4'b0011, 4'b0011};
    exp3 = '{4'b1000, 4'b0001, 4'b0010, 4'b0001};

    rst = 1'b1; ena = 1'b1; req = 4'b0000; ticks = 32'h0;
    step(); step();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_done", done, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_id", active_id, 2'd0);
    rst = 1'b0;

    // 1: single requester, delay 3
    ticks = 32'h00000003; req = 4'b0001;
    step();
    chk("t1_grant_k", grant, 4'b0001);
    chk("t1_busy_k", busy, 1'b1);
    chk("t1_id_k", active_id, 2'd0);
    req = 4'b0000;
    step();
    chk("t1_grant_k1", grant, 4'b0000);
    chk("t1_done_k1", done, 4'b0000);
    chk("t1_busy_k1", busy, 1'b1);
    step();
    chk("t1_done_k2", done, 4'b0000);
    step();
    chk("t1_done_k3", done, 4'b0001);
    chk("t1_busy_k3", busy, 1'b1);
    step();
    chk("t1_done_k4", done, 4'b0000);
    chk("t1_busy_k4", busy, 1'b0);

    // 2: three held requests, delay 2, round robin after last_id=0
    ticks = 32'h00020202; req = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_grant", grant, exp2[i]);
      chk("t2_busy", busy, 1'b1);
      run_until_done(20, n);
      chk("t2_latency", n, 2);
      chk("t2_done", done, exp2[i]);
      step();
      chk("t2_idle_busy", busy, 1'b0);
    end
    req = 4'b0000;

    // 3: last_id=1 -> 1001 grants 3 then 0; 0011 then grants 1 then 0
    ticks = 32'h01010101;
    for (int i = 0; i < 4; i++) begin
      req = req3[i];
      step();
      chk("t3_grant", grant, exp3[i]);
      run_until_done(20, n);
      chk("t3_latency", n, 1);
      chk("t3_done", done, exp3[i]);
      step();
    end
    req = 4'b0000;

    // 4: delay 4 with ena toggling; grant taken while ena=0
    ticks = 32'h00000004; req = 4'b0001; ena = 1'b0;
    step();
    chk("t4_grant_ena0", grant, 4'b0001);
    req = 4'b0000;
    first_j = 0; done_cnt = 0; done_seen = 4'b0000;
    for (int j = 1; j <= 12; j++) begin
      ena = (j % 2 == 0);
      step();
      if (done != 4'b0000) begin
        done_cnt++;
        done_seen = done;
        if (first_j == 0) first_j = j; else first_j = first_j;
      end else begin
        done_cnt = done_cnt;
      end
    end
    ena = 1'b1;
    chk("t4_done_edge", first_j, 8);
    chk("t4_done_val", done_seen, 4'b0001);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_busy_end", busy, 1'b0);

    // 5: ticks=0 behaves as 1; ticks=255 takes 255 edges
    ticks = 32'h00000000; req = 4'b0001;
    step();
    chk("t5_grant0", grant, 4'b0001);
    req = 4'b0000;
    run_until_done(20, n);
    chk("t5_latency0", n, 1);
    chk("t5_done0", done, 4'b0001);
    step();
    ticks = 32'h000000FF; req = 4'b0001;
    step();
    chk("t5_grant255", grant, 4'b0001);
    req = 4'b0000;
    run_until_done(300, n);
    chk("t5_latency255", n, 255);
    chk("t5_done255", done, 4'b0001);
    step();

    // 6: reset mid-count kills the delay and restarts arbitration at 0
    ticks = 32'h00000005; req = 4'b0010;
    step();
    chk("t6_grant", grant, 4'b0010);
    req = 4'b0000;
    step();
    rst = 1'b1;
    step();
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 4'b0000);
    chk("t6_rst_id", active_id, 2'd0);
    rst = 1'b0; req = 4'b1111;
    step();
    chk("t6_regrant", grant, 4'b0001);
    chk("t6_regrant_id", active_id, 2'd0);
    req = 4'b0000;
    step();
    chk("t6_no_done_k4", done, 4'b0000);
    step();
    chk("t6_no_done_k5", done, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
